// File: rtl/clint_mhart.sv
// Core-local interruptor for NUM_HARTS harts: 64-bit mtime with tick prescaler,
// per-hart mtimecmp/msip, registered mtip/msip outputs, valid/ready response port.
// Optional build macro CLINT_MTIME_SNAPSHOT_EN: a read of mtime lo latches mtime hi
// into a shadow so an immediately following mtime hi read is tear-free.
module clint_mhart #(
    parameter int unsigned NUM_HARTS = 1,
    parameter int unsigned TICK_DIV  = 1,
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 req_write_i,
    input  logic [31:0]          req_addr_i,
    input  logic [31:0]          req_wdata_i,
    input  logic [3:0]           req_wstrb_i,
    output logic                 resp_valid_o,
    input  logic                 resp_ready_i,
    output logic [31:0]          resp_rdata_o,
    output logic                 resp_err_o,
    output logic [NUM_HARTS-1:0] mtip_o,
    output logic [NUM_HARTS-1:0] msip_o,
    output logic [63:0]          time_o
);

    typedef enum logic [0:0] {StIdle, StResp} state_e;

    localparam logic [15:0] PrescMax = 16'(TICK_DIV - 1);

    state_e               state_q, state_d;
    logic [15:0]          presc_q, presc_d;
    logic [63:0]          mtime_q, mtime_d;
    logic [63:0]          mtimecmp_q [NUM_HARTS];
    logic [63:0]          mtimecmp_d [NUM_HARTS];
    logic [NUM_HARTS-1:0] msip_q, msip_d, mtip_q;
    logic [31:0]          rdata_q, rdata_d;
    logic                 err_q, err_d;
`ifdef CLINT_MTIME_SNAPSHOT_EN
    logic [31:0]          shadow_q, shadow_d;
    logic                 shadow_vld_q, shadow_vld_d;
`endif

    logic [31:0] msip_idx, cmp_idx;
    logic        is_msip, is_cmp, is_time, dec_err, hi, tick;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = strb[b] ? wd[8*b +: 8] : old[8*b +: 8];
        end
        return res;
    endfunction

    // Address decode of the current request
    always_comb begin
        msip_idx = {20'd0, req_addr_i[13:2]};
        cmp_idx  = {21'd0, req_addr_i[13:3]};
        hi       = req_addr_i[2];
        is_msip  = (req_addr_i[15:14] == 2'b00) && (msip_idx < NUM_HARTS);
        is_cmp   = (req_addr_i[15:14] == 2'b01) && (cmp_idx < NUM_HARTS);
        is_time  = (req_addr_i[15:3] == 13'h17FF);
        dec_err  = (req_addr_i[31:16] != BASE_ADDR[31:16]) || (req_addr_i[1:0] != 2'b00) ||
                   !(is_msip || is_cmp || is_time);
    end

    // Next-state: FSM, register access, prescaler and mtime increment
    always_comb begin
        state_d    = state_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        msip_d     = msip_q;
        mtimecmp_d = mtimecmp_q;
        tick       = (presc_q == PrescMax);
        presc_d    = tick ? 16'd0 : presc_q + 16'd1;
        mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
`ifdef CLINT_MTIME_SNAPSHOT_EN
        shadow_d     = shadow_q;
        shadow_vld_d = shadow_vld_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    state_d = StResp;
                    err_d   = dec_err;
                    rdata_d = '0;
                    if (!dec_err && req_write_i) begin
                        // An mtime write overrides a coincident tick
                        if (is_time && hi) begin
                            mtime_d = {merge(mtime_q[63:32], req_wdata_i, req_wstrb_i),
                                       mtime_q[31:0]};
                        end else if (is_time) begin
                            mtime_d = {mtime_q[63:32],
                                       merge(mtime_q[31:0], req_wdata_i, req_wstrb_i)};
                        end
                        for (int h = 0; h < NUM_HARTS; h++) begin
                            if (is_msip && msip_idx == 32'(h) && req_wstrb_i[0]) begin
                                msip_d[h] = req_wdata_i[0];
                            end
                            if (is_cmp && cmp_idx == 32'(h)) begin
                                if (hi) begin
                                    mtimecmp_d[h][63:32] = merge(mtimecmp_q[h][63:32],
                                                                 req_wdata_i, req_wstrb_i);
                                end else begin
                                    mtimecmp_d[h][31:0] = merge(mtimecmp_q[h][31:0],
                                                                req_wdata_i, req_wstrb_i);
                                end
                            end
                        end
                    end else if (!dec_err) begin
                        if (is_time && !hi) begin
                            rdata_d = mtime_q[31:0];
                        end else if (is_time) begin
`ifdef CLINT_MTIME_SNAPSHOT_EN
                            rdata_d = shadow_vld_q ? shadow_q : mtime_q[63:32];
`else
                            rdata_d = mtime_q[63:32];
`endif
                        end
                        for (int h = 0; h < NUM_HARTS; h++) begin
                            if (is_msip && msip_idx == 32'(h)) begin
                                rdata_d = {31'd0, msip_q[h]};
                            end
                            if (is_cmp && cmp_idx == 32'(h)) begin
                                rdata_d = hi ? mtimecmp_q[h][63:32] : mtimecmp_q[h][31:0];
                            end
                        end
                    end
`ifdef CLINT_MTIME_SNAPSHOT_EN
                    // Any access other than an mtime lo read invalidates the shadow
                    shadow_vld_d = 1'b0;
                    if (!dec_err && !req_write_i && is_time && !hi) begin
                        shadow_d     = mtime_q[63:32];
                        shadow_vld_d = 1'b1;
                    end
`endif
                end
            end
            StResp: begin
                if (resp_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            presc_q <= '0;
            mtime_q <= '0;
            msip_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            for (int h = 0; h < NUM_HARTS; h++) begin
                mtimecmp_q[h] <= '1;
            end
`ifdef CLINT_MTIME_SNAPSHOT_EN
            shadow_q     <= '0;
            shadow_vld_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            mtime_q    <= mtime_d;
            msip_q     <= msip_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            mtimecmp_q <= mtimecmp_d;
`ifdef CLINT_MTIME_SNAPSHOT_EN
            shadow_q     <= shadow_d;
            shadow_vld_q <= shadow_vld_d;
`endif
        end
    end

    // Timer interrupt compare on pre-update values, one cycle of lag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mtip_q <= '0;
        end else begin
            for (int h = 0; h < NUM_HARTS; h++) begin
                mtip_q[h] <= (mtime_q >= mtimecmp_q[h]);
            end
        end
    end

    assign req_ready_o  = (state_q == StIdle);
    assign resp_valid_o = (state_q == StResp);
    assign resp_rdata_o = rdata_q;
    assign resp_err_o   = err_q;
    assign mtip_o       = mtip_q;
    assign msip_o       = msip_q;
    assign time_o       = mtime_q;

endmodule

// File: doc/clint_mhart.md
Name: clint_mhart

Overview:
- Parametrised memory-mapped core-local interruptor: 64-bit mtime with programmable tick divider, per-hart mtimecmp and msip, registered per-hart mtip/msip outputs.
- Successor to the single-hart 32-bit mtime block. Sits on the data-side bus (LSU/arbiter) and feeds trap/interrupt logic in each hart's trap controller.
- Adds multi-hart support, full 64-bit compare, byte strobes, error responses and a valid/ready response handshake.

Parameters:
- NUM_HARTS, 1, number of harts; legal 1..16.
- TICK_DIV, 1, clk cycles per mtime increment; legal 1..65535; 1 = increment every cycle.
- BASE_ADDR, 32'h0200_0000, device base; only bits [31:16] are compared.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- req_valid_i  in  1  bus request valid
- req_ready_o  out  1  request accepted when valid&&ready
- req_write_i  in  1  1 = write, 0 = read
- req_addr_i  in  32  byte address, word aligned
- req_wdata_i  in  32  write data
- req_wstrb_i  in  4  byte enables for writes
- resp_valid_o  out  1  response valid
- resp_ready_i  in  1  response consumed when valid&&ready
- resp_rdata_o  out  32  read data; 0 on writes and errors
- resp_err_o  out  1  decode error
- mtip_o  out  NUM_HARTS  machine timer interrupt pending, per hart
- msip_o  out  NUM_HARTS  machine software interrupt pending, per hart
- time_o  out  64  current mtime, for the time/timeh CSRs

Behaviour:
- Interface: reset rst, asynchronous, active-high; clock clk.
- Reset values:
  - mtime = 0; prescaler = 0; every mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF; msip = 0.
  - mtip_o = 0, msip_o = 0, resp_valid_o = 0, resp_err_o = 0, resp_rdata_o = 0; FSM = IDLE.
- Address map (offset = addr[15:0]):
  - msip[h]: 0x0000 + 4h.
  - mtimecmp[h]: lo at 0x4000 + 8h, hi at 0x4004 + 8h.
  - mtime: lo at 0xBFF8, hi at 0xBFFC.
- Decode errors, any of:
  - addr[31:16] != BASE_ADDR[31:16]
  - hart index >= NUM_HARTS
  - any other offset
  - addr[1:0] != 0
- On a decode error: resp_err_o = 1, rdata = 0, no state change.
- FSM, 2 states:
  - IDLE: req_ready_o = 1. On req_valid_i, perform the access in that cycle, register rdata/err, go to RESP.
  - RESP: req_ready_o = 0, resp_valid_o = 1, outputs held stable. On resp_ready_i, go to IDLE. No back-to-back accept in the same cycle; throughput is 1 access per 2 cycles minimum.
- Read latency: rdata reflects register state at the accept edge, presented the next cycle.
- Writes:
  - Byte-merged via req_wstrb_i.
  - msip: only bit 0 writable (strb[0]); reads return {31'b0, msip[h]}.
- Prescaler and mtime increment:
  - The prescaler counts 0..TICK_DIV-1. A tick occurs when it equals TICK_DIV-1; the prescaler then wraps to 0.
  - On a tick, mtime += 1, mod 2^64; 64'hFFFF_FFFF_FFFF_FFFF wraps to 0.
- Write to mtime coinciding with a tick:
  - The written half takes the merged write data; the other half keeps its old value; no increment that cycle.
  - The tick is lost, and the prescaler still wraps.
- mtip_o[h]: registered every cycle as (mtime >= mtimecmp[h]), 64-bit unsigned, using pre-update register values.
  - mtip therefore lags a register change by 1 cycle.
  - It clears 1 cycle after mtimecmp is written above mtime.
- msip_o[h]: direct register output; changes on the cycle after the write is accepted.
- time_o: direct register output.
- Asynchronous reset mid-transaction: FSM returns to IDLE, resp_valid_o drops, any pending response is discarded.

Optional Feature:
- Macro: CLINT_MTIME_SNAPSHOT_EN.
- Defined:
  - A read of mtime lo also latches mtime[63:32] into a shadow register.
  - The next access, if it is a read of mtime hi, returns the shadow instead of live mtime hi.
  - Any other intervening access invalidates the shadow.
  - This gives RV32 software a tear-free 64-bit read.
- Undefined: mtime hi reads always return the live value; no shadow register.

Test Plan:
- Reset, then read 0x0200_BFF8 with TICK_DIV=1 → resp rdata small non-zero equal to cycles since reset; all mtip_o=0, msip_o=0, resp_err_o=0.
- NUM_HARTS=2:
  - Write mtimecmp[1] lo = 32'd100, then hi = 0 → mtip_o[1] rises exactly 1 cycle after mtime reaches 100; mtip_o[0] stays 0.
  - Then write mtimecmp[1] hi = 1 → mtip_o[1] falls 1 cycle after the write is accepted.
- Write 0x0200_0004 (msip[1]) wdata 32'hFFFF_FFFF, wstrb 4'b0001 → msip_o = 2'b10; read back = 32'h1.
- Error cases, each → resp_err_o=1, rdata=0, no register change:
  - Read 0x0200_4010 with NUM_HARTS=2
  - Read 0x0300_0000
  - Read 0x0200_BFF9
- Write mtime lo = 32'hFFFF_FFFF, hi = 0 with TICK_DIV=4 → mtime increments every 4 cycles; hi becomes 1 after 4 cycles, proving the carry.
  - Write mtime to all-ones → wraps to 0 on the next tick.
- Hold resp_ready_i=0 for 5 cycles during a read → resp_valid_o and rdata stable, req_ready_o=0.
  - Assert rst mid-RESP → resp_valid_o=0 immediately.
- With CLINT_MTIME_SNAPSHOT_EN, mtime=64'h0000_0000_FFFF_FFFE, TICK_DIV=1:
  - Read lo, then hi → hi = 0 (snapshot).
  - Without the macro → hi = 1.
